wide_add_seq: RTL and testbench

Multi-precision add sequencer that wraps the team's combinational 16-bit prefix adder. It accepts wide operands over a valid/ready handshake and feeds them to the adder one 16-bit limb per cycle, least-significant limb first. It chains the carry through a register, collects the returned sums, and presents the full-width result downstream with its own valid/ready handshake. The 16-bit adder stays a separate instance in the parent; this block drives its inputs and consumes its outputs.

---
 rtl/wadd_pkg.sv | 17 +
 rtl/wide_add_seq.sv | 140 ++++++++++++++
 tb/tb_wide_add_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wadd_pkg.sv
// Shared types and helpers for the wide add sequencer.
// Optional subtract support is enabled with WADD_SUB_EN.
package wadd_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wide_add_seq.sv
// Multi-precision add sequencer driving an external 16-bit adder limb by limb.
// Define WADD_SUB_EN to add the in_sub port and A-B support.
module wide_add_seq
    import wadd_pkg::*;
#(
    parameter  int NLIMBS = 4,
    localparam int W      = LIMB_W * NLIMBS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_cin,
`ifdef WADD_SUB_EN
    input  logic              in_sub,
`endif
    output logic [LIMB_W-1:0] add_a,
    output logic [LIMB_W-1:0] add_b,
    output logic              add_cin,
    input  logic [LIMB_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_sum,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int           CW   = cnt_width(NLIMBS);
    localparam logic [CW-1:0] LAST = CW'(NLIMBS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          sub_req;
    logic          accept;
    logic          run;
    logic          last;

`ifdef WADD_SUB_EN
    assign sub_req = in_sub;
`else
    assign sub_req = 1'b0;
`endif

    assign run    = (state_q == RUN);
    assign last   = (cnt_q == LAST);
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (run) begin
            add_a   = a_q[LIMB_W-1:0];
            add_b   = b_q[LIMB_W-1:0];
            add_cin = carry_q;
        end
    end

    // Operands shift down one limb per RUN cycle; B is stored pre-inverted for subtract.
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = in_a;
            b_d     = sub_req ? ~in_b : in_b;
            carry_d = sub_req | in_cin;
            cnt_d   = '0;
        end else if (run) begin
            a_d     = a_q >> LIMB_W;
            b_d     = b_q >> LIMB_W;
            carry_d = add_cout;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            sum_d[int'(cnt_q)*LIMB_W +: LIMB_W] = add_sum;
            if (last) begin
                cout_d = add_cout;
                ovf_d  = (add_a[LIMB_W-1] == add_b[LIMB_W-1]) &&
                         (add_sum[LIMB_W-1] != add_a[LIMB_W-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random bench for wide_add_seq with a behavioural 16-bit adder.
// Subtract cases run only when WADD_SUB_EN is defined.
module tb_wide_add_seq;
    import wadd_pkg::*;

    localparam int NL = 4;
    localparam int W  = LIMB_W * NL;

    typedef logic [W:0] cv_t;
    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_a = '0;
    logic [W-1:0]      in_b = '0;
    logic              in_cin = 1'b0;
    logic              in_sub = 1'b0;
    logic [LIMB_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_sum;
    logic              out_cout, out_ovf;
    logic [LIMB_W:0]   add_full;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic vld_prev = 1'b0;
    res_t q[$];

    always #5 clk = ~clk;

    assign add_full = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    assign add_sum  = add_full[LIMB_W-1:0];
    assign add_cout = add_full[LIMB_W];

    wide_add_seq #(.NLIMBS(NL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_cin(in_cin),
`ifdef WADD_SUB_EN
        .in_sub(in_sub),
`endif
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_sum(add_sum),
        .add_cout(add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_cout(out_cout),
        .out_ovf(out_ovf)
    );

    task automatic chk(input string nm, input cv_t act, input cv_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub);
        res_t         r;
        logic [W-1:0] be;
        cv_t          full;
        be     = sub ? ~b : b;
        full   = cv_t'(a) + cv_t'(be) + cv_t'(sub ? 1'b1 : cin);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic logic cur_sub();
`ifdef WADD_SUB_EN
        return in_sub;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: queue of expected results, one pushed per accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(ref_op(in_a, in_b, in_cin, cur_sub()));
                acc_cyc = cyc + 1;
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (!vld_prev) chk("latency", cv_t'(cyc - acc_cyc), cv_t'(NL));
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 want 0");
                end else begin
                    chk("model_sum",  cv_t'(out_sum),  cv_t'(q[0].sum));
                    chk("model_cout", cv_t'(out_cout), cv_t'(q[0].cout));
                    chk("model_ovf",  cv_t'(out_ovf),  cv_t'(q[0].ovf));
                    chk("done_in_ready", cv_t'(in_ready), cv_t'(0));
                end
            end else if (in_ready) begin
                chk("idle_add_zero", cv_t'({add_a, add_b, add_cin}), cv_t'(0));
            end
            vld_prev = out_valid;
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", cv_t'(0), cv_t'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", cv_t'(0), cv_t'(1));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input bit lit,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_valid();
        if (lit) begin
            chk("lit_sum",  cv_t'(out_sum),  cv_t'(es));
            chk("lit_cout", cv_t'(out_cout), cv_t'(ec));
            chk("lit_ovf",  cv_t'(out_ovf),  cv_t'(eo));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    initial begin
        int prev;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  cv_t'(in_ready),  cv_t'(1));
        chk("rst_out_valid", cv_t'(out_valid), cv_t'(0));
        chk("rst_out",       cv_t'({out_sum, out_cout, out_ovf}), cv_t'(0));
        chk("rst_add",       cv_t'({add_a, add_b, add_cin}), cv_t'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op(64'h1234, 64'h0001_0000, 1'b1, 1'b0, 1'b1, 64'h0001_1235, 1'b0, 1'b0);
        do_op(64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1,
              64'h0, 1'b1, 1'b1);

        // Hold in DONE with back-pressure while upstream keeps requesting.
        in_a = 64'h3; in_b = 64'h4; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_a = 64'hAAAA; in_b = 64'h5555;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", cv_t'(out_valid), cv_t'(1));
            chk("hold_ready", cv_t'(in_ready),  cv_t'(0));
            chk("hold_sum",   cv_t'(out_sum),   cv_t'(64'h7));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", cv_t'(out_valid), cv_t'(0));
        chk("release_ready", cv_t'(in_ready),  cv_t'(1));

        // Abort in the second RUN cycle while a carry is propagating.
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_cin = 1'b1;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  cv_t'(in_ready),  cv_t'(1));
        chk("abort_out_valid", cv_t'(out_valid), cv_t'(0));
        chk("abort_out",       cv_t'({out_sum, out_cout, out_ovf}), cv_t'(0));
        chk("abort_add",       cv_t'({add_a, add_b, add_cin}), cv_t'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(64'h5, 64'h10, 1'b0, 1'b0, 1'b1, 64'h15, 1'b0, 1'b0);

`ifdef WADD_SUB_EN
        do_op(64'h5, 64'h7, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        do_op(64'h7, 64'h5, 1'b1, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
`endif

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            in_a   = rnd_w();
            in_b   = rnd_w();
            in_cin = 1'($urandom);
            wait_accept();
            if (k > 0) chk("b2b_spacing", cv_t'(acc_cyc - prev), cv_t'(NL + 2));
            prev = acc_cyc;
        end
        in_valid = 1'b0;
        repeat (NL + 3) @(posedge clk);
        #1;
        out_ready = 1'b0;

        for (int k = 0; k < 20; k++) begin
            logic s = 1'b0;
`ifdef WADD_SUB_EN
            s = 1'($urandom);
`endif
            do_op(rnd_w(), rnd_w(), 1'($urandom), s, 1'b0, '0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drain", cv_t'(q.size()), cv_t'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
